// File: rtl/reaction_timer.sv
// Reaction-speed tester core: random pre-delay, stimulus LED, 4-digit BCD reaction count
// in 100 us ticks, with early-press (foul) detection and saturation at 9999.
module reaction_timer #(
  parameter int unsigned MIN_DELAY_TICKS = 10000,
  parameter int unsigned RAND_BITS       = 14,
  parameter bit          RAND_EN         = 1'b1,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        division_clk,
  input  logic        start,
  input  logic        react,
  output logic        led_on,
  output logic [15:0] time_bcd,
  output logic        result_valid,
  output logic        foul,
  output logic        overflow
);

  typedef enum logic [2:0] {IDLE, WAIT, COUNT, DONE, FOUL} state_t;

  localparam logic [15:0] MIN_D = 16'(MIN_DELAY_TICKS);

  state_t      state, state_nxt;
  logic        div_q, div_p, tick;
  logic [15:0] lfsr;
  logic [15:0] delay_cnt, delay_cnt_nxt;
  logic [15:0] delay_target, delay_target_nxt;
  logic [15:0] rand_term, target_new, time_inc, time_nxt;
  logic [16:0] delay_sum;
  logic        led_nxt, rv_nxt, foul_nxt, ovf_nxt;

  assign tick = div_q & ~div_p;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
        else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Delay latched at start: minimum plus zero-extended random term, clipped to 16 bits.
  always_comb begin
    rand_term = '0;
    if (RAND_EN) rand_term[RAND_BITS-1:0] = lfsr[RAND_BITS-1:0];
    delay_sum  = {1'b0, MIN_D} + {1'b0, rand_term};
    target_new = delay_sum[16] ? 16'hFFFF : delay_sum[15:0];
    time_inc   = bcd_inc(time_bcd);
  end

  always_comb begin
    state_nxt        = state;
    delay_cnt_nxt    = delay_cnt;
    delay_target_nxt = delay_target;
    time_nxt         = time_bcd;
    led_nxt          = led_on;
    rv_nxt           = result_valid;
    foul_nxt         = foul;
    ovf_nxt          = overflow;
    case (state)
      IDLE: begin
        led_nxt  = 1'b0;
        rv_nxt   = 1'b0;
        foul_nxt = 1'b0;
        ovf_nxt  = 1'b0;
        time_nxt = '0;
        if (start) begin
          state_nxt        = WAIT;
          delay_target_nxt = target_new;
          delay_cnt_nxt    = '0;
        end
      end
      WAIT: begin
        if (react) begin
          state_nxt = FOUL;
          foul_nxt  = 1'b1;
          time_nxt  = '0;
          led_nxt   = 1'b0;
        end else if (delay_cnt == delay_target) begin
          state_nxt = COUNT;
          led_nxt   = 1'b1;
          time_nxt  = '0;
        end else if (tick) begin
          delay_cnt_nxt = delay_cnt + 16'd1;
        end
      end
      COUNT: begin
        led_nxt = 1'b1;
        // A react coinciding with a tick wins; that tick is dropped.
        if (react) begin
          state_nxt = DONE;
          led_nxt   = 1'b0;
          rv_nxt    = 1'b1;
        end else begin
          if (tick && time_bcd != 16'h9999) time_nxt = time_inc;
          ovf_nxt = (time_nxt == 16'h9999);
        end
      end
      DONE: begin
        led_nxt = 1'b0;
        if (start) begin
          state_nxt        = WAIT;
          rv_nxt           = 1'b0;
          ovf_nxt          = 1'b0;
          time_nxt         = '0;
          delay_target_nxt = target_new;
          delay_cnt_nxt    = '0;
        end
      end
      FOUL: begin
        foul_nxt = 1'b1;
        time_nxt = '0;
        led_nxt  = 1'b0;
        if (start) begin
          state_nxt        = WAIT;
          foul_nxt         = 1'b0;
          delay_target_nxt = target_new;
          delay_cnt_nxt    = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      div_q        <= 1'b0;
      div_p        <= 1'b0;
      lfsr         <= LFSR_SEED;
      delay_cnt    <= '0;
      delay_target <= '0;
      time_bcd     <= '0;
      led_on       <= 1'b0;
      result_valid <= 1'b0;
      foul         <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      state        <= state_nxt;
      div_q        <= division_clk;
      div_p        <= div_q;
      lfsr         <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      delay_cnt    <= delay_cnt_nxt;
      delay_target <= delay_target_nxt;
      time_bcd     <= time_nxt;
      led_on       <= led_nxt;
      result_valid <= rv_nxt;
      foul         <= foul_nxt;
      overflow     <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_reaction_timer.sv
// Scoreboard bench for reaction_timer: trials push expected results, monitors compare on
// result/foul events and on LED onset (random-delay instance).
module tb_reaction_timer;

  typedef struct packed {
    logic [15:0] t;
    logic        rv;
    logic        f;
    logic        ov;
    logic        led;
  } res_t;

  logic        sysclk = 1'b0;
  logic        reset, division_clk, start, react;
  logic        led_on, result_valid, foul, overflow;
  logic [15:0] time_bcd;
  logic        rst2, start2, react2;
  logic        led2, rv2, foul2, ovf2;
  logic [15:0] time2;

  int   n_chk = 0;
  int   n_fail = 0;
  int   div_half = 50;
  res_t exp_q[$];
  int   exp2_q[$];
  logic [15:0] m_lfsr;

  reaction_timer #(.MIN_DELAY_TICKS(4), .RAND_BITS(14), .RAND_EN(1'b0)) u_dut (
    .sysclk(sysclk), .reset(reset), .division_clk(division_clk), .start(start), .react(react),
    .led_on(led_on), .time_bcd(time_bcd), .result_valid(result_valid), .foul(foul),
    .overflow(overflow));

  reaction_timer #(.MIN_DELAY_TICKS(4), .RAND_BITS(4), .RAND_EN(1'b1)) u_dut2 (
    .sysclk(sysclk), .reset(rst2), .division_clk(division_clk), .start(start2), .react(react2),
    .led_on(led2), .time_bcd(time2), .result_valid(rv2), .foul(foul2), .overflow(ovf2));

  always #5 sysclk = ~sysclk;

  initial begin
    division_clk = 1'b0;
    forever begin
      repeat (div_half) @(negedge sysclk);
      division_clk = ~division_clk;
    end
  end

  // Reference 16-bit Fibonacci LFSR, taps 16,14,13,11.
  always @(posedge sysclk or posedge rst2)
    if (rst2) m_lfsr <= 16'hACE1;
    else      m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitors sample 2 ns after each rising sysclk edge.
  logic ev_prev = 1'b0, led2_prev = 1'b0, div_prev = 1'b0;
  int   cnt2 = 0;
  always @(posedge sysclk) begin
    #2;
    if ((result_valid | foul) && !ev_prev) begin
      if (exp_q.size() == 0) check("unexpected_result", 32'd1, 32'd0);
      else check("result", {time_bcd, result_valid, foul, overflow, led_on}, exp_q.pop_front());
    end
    ev_prev = result_valid | foul;
    if (start2) cnt2 = 0;
    if (division_clk && !div_prev) cnt2++;
    div_prev = division_clk;
    if (led2 && !led2_prev) begin
      if (exp2_q.size() == 0) check("unexpected_led", 32'd1, 32'd0);
      else begin
        check("t6_delay_model", cnt2, exp2_q.pop_front());
        check("t6_delay_range", (cnt2 >= 4 && cnt2 <= 19), 32'd1);
      end
    end
    led2_prev = led2;
  end

  task automatic pulse_start();
    @(negedge sysclk) start = 1'b1;
    @(negedge sysclk) start = 1'b0;
  endtask

  task automatic pulse_react();
    @(negedge sysclk) react = 1'b1;
    @(negedge sysclk) react = 1'b0;
  endtask

  task automatic pulse_start2();
    @(negedge sysclk) start2 = 1'b1;
    exp2_q.push_back(4 + int'(m_lfsr[3:0]));
    @(negedge sysclk) start2 = 1'b0;
  endtask

  task automatic align();
    @(posedge division_clk);
    repeat (5) @(negedge sysclk);
  endtask

  task automatic wait_led(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(negedge sysclk);
      if (led_on) ok = 1'b1;
    end
  endtask

  task automatic wait_led2(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(negedge sysclk);
      if (led2) ok = 1'b1;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    reset = 1'b1; start = 1'b0; react = 1'b0;
    rst2 = 1'b1; start2 = 1'b0; react2 = 1'b0;
    repeat (3) @(negedge sysclk);
    check("reset_outputs", {time_bcd, result_valid, foul, overflow, led_on}, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge sysclk);
    check("idle_outputs", {time_bcd, result_valid, foul, overflow, led_on}, 32'd0);

    // 1: react 37 ticks after LED
    align();
    exp_q.push_back('{16'h0037, 1'b1, 1'b0, 1'b0, 1'b0});
    pulse_start();
    wait_led(ok);
    check("t1_led", ok, 32'd1);
    repeat (37) @(posedge division_clk);
    repeat (5) @(negedge sysclk);
    pulse_react();
    repeat (5) @(negedge sysclk);

    // 2: early press
    align();
    exp_q.push_back('{16'h0000, 1'b0, 1'b1, 1'b0, 1'b0});
    pulse_start();
    repeat (2) @(posedge division_clk);
    repeat (5) @(negedge sysclk);
    check("t2_led_off", led_on, 32'd0);
    pulse_react();
    repeat (5) @(negedge sysclk);

    // 4: react on the same cycle as the tick that would give 0013
    align();
    exp_q.push_back('{16'h0012, 1'b1, 1'b0, 1'b0, 1'b0});
    pulse_start();
    repeat (2) @(negedge sysclk);
    check("t4_foul_cleared", foul, 32'd0);
    wait_led(ok);
    check("t4_led", ok, 32'd1);
    repeat (13) @(posedge division_clk);
    @(posedge sysclk);
    @(negedge sysclk) react = 1'b1;
    @(negedge sysclk) react = 1'b0;
    repeat (5) @(negedge sysclk);

    // 3: saturation, fast timebase
    div_half = 1;
    align();
    exp_q.push_back('{16'h9999, 1'b1, 1'b0, 1'b1, 1'b0});
    pulse_start();
    repeat (2) @(negedge sysclk);
    check("t3_rv_cleared", result_valid, 32'd0);
    wait_led(ok);
    check("t3_led", ok, 32'd1);
    repeat (10010) @(posedge division_clk);
    repeat (3) @(negedge sysclk);
    check("t3_time", time_bcd, 32'h9999);
    check("t3_ovf", overflow, 32'd1);
    pulse_react();
    repeat (5) @(negedge sysclk);

    // 5: async reset mid-count, then a clean trial
    align();
    pulse_start();
    wait_led(ok);
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge sysclk);
      if (time_bcd == 16'h0250) ok = 1'b1;
    end
    check("t5_reach_0250", ok, 32'd1);
    #2 reset = 1'b1;
    #1 check("t5_async_reset", {time_bcd, result_valid, foul, overflow, led_on}, 32'd0);
    @(negedge sysclk) reset = 1'b0;
    div_half = 50;
    align();
    exp_q.push_back('{16'h0005, 1'b1, 1'b0, 1'b0, 1'b0});
    pulse_start();
    wait_led(ok);
    check("t5_led", ok, 32'd1);
    repeat (5) @(posedge division_clk);
    repeat (5) @(negedge sysclk);
    pulse_react();
    repeat (5) @(negedge sysclk);

    // 6: random delay, two back-to-back trials from reset
    rst2 = 1'b1;
    repeat (2) @(negedge sysclk);
    rst2 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      align();
      pulse_start2();
      wait_led2(ok);
      check("t6_led", ok, 32'd1);
      repeat (2) @(posedge division_clk);
      repeat (5) @(negedge sysclk);
      @(negedge sysclk) react2 = 1'b1;
      @(negedge sysclk) react2 = 1'b0;
      repeat (3) @(negedge sysclk);
      check("t6_result_valid", rv2, 32'd1);
    end

    repeat (5) @(negedge sysclk);
    check("scoreboard_drain", exp_q.size() + exp2_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
